matrix_keypad_scanner: RTL and testbench

- Parametrised ROWS x COLS matrix keypad scanner for the calculator and later front panels; generalises the fixed 4x4 scanner.
- Adds per-frame debouncing, press and release events, auto-repeat, and a buffered event FIFO with a valid/ready handshake.
- Emits raw key indices; mapping to calculator symbols is done downstream by a separate decoder.

---
 rtl/matrix_keypad_scanner.sv | 130 +++++++++++++
 tb/tb_matrix_keypad_scanner.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_keypad_scanner.sv
// matrix_keypad_scanner: debounced ROWS x COLS keypad scan with press/release/repeat events in a FWFT FIFO
`timescale 1ns/1ps
module matrix_keypad_scanner #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int SCAN_DIV = 1000000,
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int REPEAT_DELAY = 30,
  parameter int REPEAT_RATE = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CODE_W = $clog2(ROWS*COLS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ROWS-1:0]        row_n,
  output logic [COLS-1:0]        col_n,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [CODE_W-1:0]      ev_code,
  output logic                   ev_release,
  output logic                   ev_repeat,
  output logic [ROWS*COLS-1:0]   key_state,
  output logic                   overflow,
  input  logic                   clr_ovf
);
  localparam int N = ROWS*COLS;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int CIW = COLS > 1 ? $clog2(COLS) : 1;
  localparam int SW = $clog2(DEBOUNCE_FRAMES+1);
  localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX+1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = CODE_W + 2;
  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV-1);
  localparam logic [CIW-1:0] C_LAST = CIW'(COLS-1);
  localparam logic [SW-1:0] S_MAX = SW'(DEBOUNCE_FRAMES);
  localparam logic [RW-1:0] R_DLY = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_RATE = RW'(REPEAT_RATE);

  logic run, tick, frame_stb, upd, one_hot, rep_phase, rep_fire, push;
  logic [ROWS-1:0] row_m, row_s;
  logic [PW-1:0] pcnt;
  logic [CIW-1:0] col_idx;
  logic [N-1:0] raw, prev, pending;
  logic [SW-1:0] stable_cnt, stable_nxt;
  logic [RW-1:0] rep_cnt, rep_nxt;
  logic [EW-1:0] push_ev;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic full, pop, wr_en, ovf_set;

  function automatic logic [CODE_W-1:0] low_idx(input logic [N-1:0] v);
    low_idx = '0;
    for (int i = N-1; i >= 0; i--)
      if (v[i]) low_idx = CODE_W'(i);
  endfunction

  assign col_n = run ? ~(COLS'(1) << col_idx) : '1;

  always_comb begin
    tick = pcnt == P_LAST;
    stable_nxt = raw != prev ? SW'(1) : stable_cnt == S_MAX ? S_MAX : stable_cnt + 1'b1;
    upd = frame_stb && stable_nxt == S_MAX && raw != key_state;
    one_hot = |key_state && ~|(key_state & (key_state - 1'b1));
    rep_nxt = rep_cnt + 1'b1;
    rep_fire = REPEAT_DELAY > 0 && frame_stb && !upd && one_hot && rep_nxt == (rep_phase ? R_RATE : R_DLY);
    push = |pending || rep_fire;
    // pending never overlaps a repeat: it is empty on every frame strobe
    push_ev = |pending ? {1'b0, ~key_state[low_idx(pending)], low_idx(pending)}
                       : {1'b1, 1'b0, low_idx(key_state)};
    ev_valid = wr_ptr != rd_ptr;
    full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    pop = ev_valid && ev_ready;
    wr_en = push && (!full || pop);
    ovf_set = push && full && !pop;
    {ev_repeat, ev_release, ev_code} = ev_valid ? mem[rd_ptr[AW-1:0]] : '0;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      run <= 1'b0;
      row_m <= '1;
      row_s <= '1;
      pcnt <= '0;
      col_idx <= '0;
      frame_stb <= 1'b0;
      raw <= '0;
      prev <= '0;
      stable_cnt <= '0;
      key_state <= '0;
      pending <= '0;
      rep_cnt <= '0;
      rep_phase <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      overflow <= 1'b0;
    end else begin
      run <= 1'b1;
      row_m <= row_n;
      row_s <= row_m;
      frame_stb <= 1'b0;
      if (run) pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick) begin
        raw[int'(col_idx)*ROWS +: ROWS] <= ~row_s;
        col_idx <= col_idx == C_LAST ? '0 : col_idx + 1'b1;
        frame_stb <= col_idx == C_LAST;
      end
      if (frame_stb) begin
        prev <= raw;
        stable_cnt <= stable_nxt;
      end
      if (upd) begin
        key_state <= raw;
        pending <= raw ^ key_state;
      end else pending <= pending & (pending - 1'b1);
      if (frame_stb && (upd || !one_hot)) begin
        rep_cnt <= '0;
        rep_phase <= 1'b0;
      end else if (rep_fire) begin
        rep_cnt <= '0;
        rep_phase <= 1'b1;
      end else if (frame_stb) rep_cnt <= rep_nxt;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      overflow <= ovf_set || (overflow && !clr_ovf);
    end

  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_ev;
endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// tb_matrix_keypad_scanner: table-driven keypad scenarios plus overflow and mid-frame reset sequences
`timescale 1ns/1ps
module tb_matrix_keypad_scanner;
  logic clk = 1'b0, rst = 1'b1, ev_ready = 1'b1, clr_ovf = 1'b0;
  logic [3:0] row_n, col_n, ev_code;
  logic ev_valid, ev_release, ev_repeat, overflow;
  logic [15:0] key_state, keys = '0;
  int n_tests = 0, n_fail = 0, fr = 0;

  typedef struct {
    logic [3:0] code;
    logic rel;
    logic rep;
    int fr;
  } ev_t;
  typedef struct {
    logic [15:0] keys;
    int frames;
    logic [15:0] ks;
    int n_ev;
    int n_rep;
    logic [3:0] c0;
    logic r0;
    logic [3:0] c1;
    logic r1;
    logic p1;
    int rep_fr;
    int last_fr;
  } vec_t;
  ev_t evq[$];
  vec_t tbl[8];
  logic [3:0] exp_codes[4];

  matrix_keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(40), .DEBOUNCE_FRAMES(2),
    .REPEAT_DELAY(3), .REPEAT_RATE(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_code(ev_code), .ev_release(ev_release), .ev_repeat(ev_repeat),
    .key_state(key_state), .overflow(overflow), .clr_ovf(clr_ovf));

  always #5 clk = ~clk;

  // key k sits at column k/4, row k%4 and shorts its row low while its column is driven
  always_comb begin
    row_n = '1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4+r] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(negedge clk)
    if (ev_valid && ev_ready) evq.push_back('{ev_code, ev_release, ev_repeat, fr});

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic next_frame();
    logic [3:0] p;
    p = col_n;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (col_n == 4'b1110 && p == 4'b0111) begin
        fr++;
        return;
      end
      p = col_n;
    end
    n_tests++;
    n_fail++;
    $display("FAIL frame_wait: no frame start within 400 cycles, col_n=%b", col_n);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk) chk("col_idle_after_rst", 32'(col_n), 32'hf);
    @(posedge clk);
    @(negedge clk) chk("col0_first_clk", 32'(col_n), 32'he);
    repeat (39) @(posedge clk);
    @(negedge clk) chk("col0_low_time", 32'(col_n), 32'he);
    @(posedge clk);
    @(negedge clk) chk("col1_step", 32'(col_n), 32'hd);
  endtask

  initial begin
    tbl[0] = '{16'h0200, 2, 16'h0200, 1, 0, 4'd9, 1'b0, 4'd9, 1'b0, 1'b0, 0, 2};
    tbl[1] = '{16'h0000, 2, 16'h0000, 1, 0, 4'd9, 1'b1, 4'd9, 1'b1, 1'b0, 0, 2};
    tbl[2] = '{16'h0020, 1, 16'h0000, 0, 0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 0, 0};
    tbl[3] = '{16'h0000, 2, 16'h0000, 0, 0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 0, 0};
    tbl[4] = '{16'h1008, 6, 16'h1008, 2, 0, 4'd3, 1'b0, 4'd12, 1'b0, 1'b0, 0, 2};
    tbl[5] = '{16'h0000, 2, 16'h0000, 2, 0, 4'd3, 1'b1, 4'd12, 1'b1, 1'b0, 0, 2};
    tbl[6] = '{16'h0001, 11, 16'h0001, 5, 4, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 5, 11};
    tbl[7] = '{16'h0000, 2, 16'h0000, 1, 0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 0, 2};
    exp_codes = '{4'd1, 4'd2, 4'd6, 4'd10};

    cycles(3);
    @(negedge clk);
    chk("rst_col_n", 32'(col_n), 32'hf);
    chk("rst_ev_valid", 32'(ev_valid), 0);
    chk("rst_ev_fields", 32'({ev_code, ev_release, ev_repeat}), 0);
    chk("rst_key_state", 32'(key_state), 0);
    chk("rst_overflow", 32'(overflow), 0);
    release_reset();
    repeat (2) next_frame();
    cycles(20);

    for (int i = 0; i < 8; i++) begin
      int nrep, rf;
      evq.delete();
      fr = 0;
      keys = tbl[i].keys;
      repeat (tbl[i].frames) next_frame();
      cycles(20);
      @(negedge clk);
      chk($sformatf("v%0d_key_state", i), 32'(key_state), 32'(tbl[i].ks));
      chk($sformatf("v%0d_n_events", i), evq.size(), tbl[i].n_ev);
      nrep = 0;
      rf = -1;
      foreach (evq[j]) begin
        nrep += int'(evq[j].rep);
        if (evq[j].rep && rf < 0) rf = evq[j].fr;
      end
      chk($sformatf("v%0d_n_repeats", i), nrep, tbl[i].n_rep);
      if (tbl[i].n_ev > 0 && evq.size() > 0) begin
        chk($sformatf("v%0d_first_code", i), 32'(evq[0].code), 32'(tbl[i].c0));
        chk($sformatf("v%0d_first_release", i), 32'(evq[0].rel), 32'(tbl[i].r0));
        chk($sformatf("v%0d_first_repeat", i), 32'(evq[0].rep), 0);
        chk($sformatf("v%0d_last_code", i), 32'(evq[$].code), 32'(tbl[i].c1));
        chk($sformatf("v%0d_last_release", i), 32'(evq[$].rel), 32'(tbl[i].r1));
        chk($sformatf("v%0d_last_repeat", i), 32'(evq[$].rep), 32'(tbl[i].p1));
        chk($sformatf("v%0d_last_frame", i), evq[$].fr, tbl[i].last_fr);
      end
      if (tbl[i].n_rep > 0) chk($sformatf("v%0d_first_repeat_frame", i), rf, tbl[i].rep_fr);
    end

    ev_ready = 1'b0;
    evq.delete();
    keys = 16'h8446;
    repeat (2) next_frame();
    cycles(20);
    @(negedge clk);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_valid", 32'(ev_valid), 1);
    chk("ovf_head_code", 32'(ev_code), 1);
    chk("ovf_key_state", 32'(key_state), 32'h8446);
    cycles(5);
    @(negedge clk);
    chk("stall_hold_code", 32'(ev_code), 1);
    chk("stall_hold_kind", 32'({ev_release, ev_repeat}), 0);
    @(posedge clk);
    #1 clr_ovf = 1'b1;
    @(posedge clk);
    #1 clr_ovf = 1'b0;
    @(negedge clk) chk("ovf_clear", 32'(overflow), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("fifo%0d_valid", i), 32'(ev_valid), 1);
      chk($sformatf("fifo%0d_code", i), 32'(ev_code), 32'(exp_codes[i]));
      @(posedge clk);
      #1 ev_ready = 1'b1;
      @(posedge clk);
      #1 ev_ready = 1'b0;
    end
    @(negedge clk) chk("fifo_drained", 32'(ev_valid), 0);

    next_frame();
    keys = '0;
    repeat (2) next_frame();
    cycles(20);
    @(negedge clk);
    chk("refill_overflow", 32'(overflow), 1);
    chk("refill_valid", 32'(ev_valid), 1);
    chk("refill_head", 32'({ev_code, ev_release}), 32'({4'd1, 1'b1}));
    cycles(50);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'(ev_valid), 0);
    chk("midrst_col_n", 32'(col_n), 32'hf);
    chk("midrst_key_state", 32'(key_state), 0);
    chk("midrst_overflow", 32'(overflow), 0);
    cycles(3);
    release_reset();
    ev_ready = 1'b1;
    evq.delete();
    repeat (3) next_frame();
    cycles(20);
    @(negedge clk);
    chk("post_rst_events", evq.size(), 0);
    chk("post_rst_key_state", 32'(key_state), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
